cloud_scheduler: RTL and testbench
==================================

// Module: cloud_scheduler
// PURPOSE
//  Owns all background cloud sprites: spawns, scrolls and retires up to NUM_CLOUDS
//  clouds, one slot per Clk cycle, once per detected frame_clk rising edge. Sits
//  between the VGA frame tick and the color mapper, which reads CloudX/CloudY/CloudActive.
//  Replaces per-cloud free-running movers with one sequenced, shared update engine.
// PARAMETERS
//  NUM_CLOUDS  4        number of cloud slots (1..8)
//  CLOUD_W     100      cloud width in pixels; retire threshold
//  SCREEN_W    640      spawn X (first column right of visible area)
//  SPEED       1        pixels moved left per frame (1..15)
//  Y_BASE      20       minimum spawn Y; spawn Y = Y_BASE + lfsr[6:0]
//  SPAWN_GAP   120      minimum frames between spawns
//  LFSR_SEED   16'hACE1 LFSR reset value, must be nonzero
// PORTS
//  Clk          in   1            system clock
//  Reset_n      in   1            asynchronous, active-low reset
//  frame_clk    in   1            VGA frame strobe, asynchronous to Clk; 2-FF synced
//  Enable       in   1            1: process ticks; 0: ticks ignored, state frozen
//  Clear        in   1            sync: deactivate all slots, reload spawn timer
//  CloudX       out  NUM_CLOUDS*11 per-slot left edge, signed 11b, slot i at [11i+:11]
//  CloudY       out  NUM_CLOUDS*10 per-slot top edge, unsigned
//  CloudActive  out  NUM_CLOUDS   per-slot valid
//  Busy         out  1            high while FSM not IDLE
//  FrameDone    out  1            one-cycle pulse when a frame update completes
// BEHAVIOUR
//  Reset: all slots inactive, CloudX=SCREEN_W, CloudY=Y_BASE, Busy=0, FrameDone=0,
//   spawn_cnt=0 (first spawn on first frame), lfsr=LFSR_SEED, pending=0, state IDLE.
//  Tick: rising edge of synced frame_clk, registered; tick visible cycle t.
//  FSM IDLE -> SCAN (t+1) when tick&Enable or pending; clears pending.
//   SCAN: idx 0..NUM_CLOUDS-1, one slot/cycle; active slot: x <= x - SPEED;
//    if (x - SPEED) <= -CLOUD_W then active <= 0. Inactive slots untouched.
//   SPAWN (1 cycle): if spawn_cnt==0 and a free slot exists (post-SCAN): lowest free
//    index gets active=1, x=SCREEN_W, y=Y_BASE+lfsr[6:0]; spawn_cnt <= SPAWN_GAP +
//    lfsr[11:8]. Else if spawn_cnt>0: spawn_cnt-1. No free slot: holds 0, retry next frame.
//    LFSR (16b Galois, mask 16'hB400) advances exactly once per SPAWN cycle.
//   DONE (1 cycle): FrameDone=1 -> IDLE. Total latency tick->FrameDone = NUM_CLOUDS+2.
//  Tick while Busy: sets pending (single bit); further ticks while pending are dropped.
//  Enable=0: ticks and pending ignored; an update in progress runs to DONE.
//  Clear: highest priority over FSM; any state -> IDLE, all inactive, pending=0,
//   spawn_cnt <= SPAWN_GAP, FrameDone not pulsed. LFSR not reset by Clear.
//  Reset_n mid-update: immediate return to reset values, no partial slot state kept.
//  Arithmetic: x held signed 11b; range [-CLOUD_W, SCREEN_W]; y never wraps
//   (Y_BASE+127 <= 479 is a parameter constraint, checked by elaboration assert).
//  Outputs registered; slot outputs change only in SCAN/SPAWN/Clear cycles.
// STRUCTURE
//  cloud_pkg: sched_state_e {IDLE,SCAN,SPAWN,DONE}; cloud_t {active, x[10:0], y[9:0]};
//   localparams X_W=11, Y_W=10, LFSR_MASK=16'hB400.
//  Sub-module cloud_lfsr (Clk, Reset_n, step, seed param, q[15:0]).
//  Top: sync+edge detect, FSM, slot array cloud_t [NUM_CLOUDS], spawn counter,
//   free-slot priority encoder, output flattening.
// TESTING
//  Reset then 1 tick -> FrameDone at t+6 (N=4); slot0 active x=640,
//   y=20+(seed-derived lfsr[6:0]); spawn_cnt=120+lfsr[11:8].
//  Single cloud, 740 ticks -> x decrements 1/frame; retires on frame where x-1 <= -100
//   (x=-100), CloudActive[0]=0 same cycle.
//  Force all 4 slots active, spawn_cnt=0 -> no spawn, cnt holds 0; retire slot2 ->
//   next frame spawns into slot2 (lowest free).
//  frame_clk edge during SCAN, second edge before DONE -> exactly one extra update
//   (pending), two FrameDone pulses total.
//  Clear asserted in SCAN idx=2 -> IDLE next cycle, all inactive, no FrameDone,
//   next spawn after 120 frames; Enable=0 for 10 ticks -> outputs unchanged.
//  Reset_n low mid-SCAN -> outputs at reset values same cycle (async), LFSR=seed.

Source files
------------

// File: rtl/cloud_pkg.sv
// cloud_pkg: shared types, field widths and the LFSR step function used by
// the cloud scheduler and its LFSR sub-module.
//   sched_state_e : update-engine FSM states
//   cloud_t       : one cloud slot {active, x (signed 11b), y (unsigned 10b)}
//   lfsr_next()   : one step of the 16-bit Galois LFSR
package cloud_pkg;

  localparam int          X_W       = 11;
  localparam int          Y_W       = 10;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SPAWN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic           active;
    logic [X_W-1:0] x;      // left edge, two's complement
    logic [Y_W-1:0] y;      // top edge
  } cloud_t;

  // Galois form: shift right, fold the mask in when the bit shifted out is 1
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/cloud_lfsr.sv
// cloud_lfsr: 16-bit Galois LFSR that advances by one step whenever 'step'
// is high. Provides the pseudo-random spawn height and spawn gap jitter.
//   Clk     in   system clock
//   Reset_n in   asynchronous active-low reset, loads SEED
//   step    in   advance one step this cycle
//   q       out  current LFSR state
module cloud_lfsr
  import cloud_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] lfsr_r;

  // LFSR state register; holds its value unless stepped
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_r <= SEED;
    end else if (step) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign q = lfsr_r;

endmodule

// File: rtl/cloud_scheduler.sv
// cloud_scheduler: owns all background cloud slots. On each rising edge of
// the (asynchronous) frame strobe it walks the slots one per cycle, scrolling
// active clouds left and retiring those that have left the screen, then
// optionally spawns a new cloud into the lowest free slot.
//   Clk          in   system clock
//   Reset_n      in   asynchronous active-low reset
//   frame_clk    in   VGA frame strobe, asynchronous to Clk
//   Enable       in   1: frame ticks start updates, 0: ticks ignored
//   Clear        in   synchronous: retire all slots, abort update, reload gap
//   CloudX       out  slot i left edge (signed) at [11i +: 11]
//   CloudY       out  slot i top edge at [10i +: 10]
//   CloudActive  out  slot i valid at [i]
//   Busy         out  update engine not idle
//   FrameDone    out  one-cycle pulse at the end of every completed update
module cloud_scheduler
  import cloud_pkg::*;
#(
  parameter int          NUM_CLOUDS = 4,
  parameter int          CLOUD_W    = 100,
  parameter int          SCREEN_W   = 640,
  parameter int          SPEED      = 1,
  parameter int          Y_BASE     = 20,
  parameter int          SPAWN_GAP  = 120,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_clk,
  input  logic                      Enable,
  input  logic                      Clear,
  output logic [NUM_CLOUDS*X_W-1:0] CloudX,
  output logic [NUM_CLOUDS*Y_W-1:0] CloudY,
  output logic [NUM_CLOUDS-1:0]     CloudActive,
  output logic                      Busy,
  output logic                      FrameDone
);

  localparam int               IDX_W    = (NUM_CLOUDS > 1) ? $clog2(NUM_CLOUDS) : 1;
  localparam int               CNT_W    = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLOUDS - 1);
  localparam logic [X_W-1:0]   SPEED_X  = X_W'(SPEED);
  localparam logic [X_W-1:0]   SPAWN_X  = X_W'(SCREEN_W);
  localparam logic [X_W-1:0]   RETIRE_X = X_W'(-CLOUD_W);
  localparam logic [Y_W-1:0]   Y_BASE_Y = Y_W'(Y_BASE);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(SPAWN_GAP);

  // Parameter sanity: y must never wrap and the slot count must fit the encoding
  if ((Y_BASE + 127 > 479) || (NUM_CLOUDS < 1) || (NUM_CLOUDS > 8) ||
      (SPEED < 1) || (SPEED > 15) || (LFSR_SEED == 16'h0000)) begin : g_param_check
    $error("cloud_scheduler: illegal parameter combination");
  end

  logic [1:0]       frame_sync_r;
  logic             frame_prev_r;
  logic             tick_r;
  sched_state_e     state_r, state_s;
  logic [IDX_W-1:0] idx_r;
  logic             pending_r;
  cloud_t           slots_r [NUM_CLOUDS];
  logic [CNT_W-1:0] spawn_cnt_r;
  logic             busy_r;
  logic             frame_done_r;
  logic [15:0]      lfsr_q_s;
  logic             lfsr_step_s;
  logic             lfsr_unused_s;
  logic             free_found_s;
  logic [IDX_W-1:0] free_idx_s;
  logic [X_W-1:0]   x_dec_s;
  logic             retire_s;
  logic [Y_W-1:0]   spawn_y_s;
  logic             spawn_now_s;

  // Two-flop synchroniser plus registered rising-edge detector for frame_clk
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_sync_r <= 2'b00;
      frame_prev_r <= 1'b0;
      tick_r       <= 1'b0;
    end else begin
      frame_sync_r <= {frame_sync_r[0], frame_clk};
      frame_prev_r <= frame_sync_r[1];
      tick_r       <= frame_sync_r[1] & ~frame_prev_r;
    end
  end

  // FSM next state; Clear overrides everything and lands in IDLE
  always_comb begin
    state_s = state_r;
    if (Clear) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = (Enable && (tick_r || pending_r)) ? SCAN : IDLE;
        SCAN:    state_s = (idx_r == LAST_IDX) ? SPAWN : SCAN;
        SPAWN:   state_s = DONE;
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // FSM state, slot index and registered status outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= (state_r == SCAN && !Clear && idx_r != LAST_IDX) ? idx_r + 1'b1 : '0;
      busy_r       <= (state_s != IDLE);
      frame_done_r <= (state_r == SPAWN) && !Clear;
    end
  end

  // One-deep memory of a tick that arrived while an update was running
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_r <= 1'b0;
    end else if (Clear) begin
      pending_r <= 1'b0;
    end else if (state_r == IDLE && state_s == SCAN) begin
      pending_r <= 1'b0;
    end else if (tick_r && Enable && state_r != IDLE) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Scroll arithmetic for the slot currently addressed by the scan index
  always_comb begin
    x_dec_s  = slots_r[idx_r].x - SPEED_X;
    retire_s = ($signed(x_dec_s) <= $signed(RETIRE_X));
  end

  // Lowest-index free slot; scanning downward lets the lowest index win
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = NUM_CLOUDS - 1; i >= 0; i--) begin
      if (!slots_r[i].active) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  assign spawn_y_s     = Y_BASE_Y + {{(Y_W-7){1'b0}}, lfsr_q_s[6:0]};
  assign spawn_now_s   = (state_r == SPAWN) && (spawn_cnt_r == '0) && free_found_s;
  assign lfsr_step_s   = (state_r == SPAWN) && !Clear;
  assign lfsr_unused_s = ^{lfsr_q_s[15:12], lfsr_q_s[7]};

  // Slot array: scroll/retire during SCAN, spawn during SPAWN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_CLOUDS; i++) begin
        slots_r[i].active <= 1'b0;
        slots_r[i].x      <= SPAWN_X;
        slots_r[i].y      <= Y_BASE_Y;
      end
    end else if (Clear) begin
      for (int i = 0; i < NUM_CLOUDS; i++) begin
        slots_r[i].active <= 1'b0;
      end
    end else if (state_r == SCAN && slots_r[idx_r].active) begin
      slots_r[idx_r].x      <= x_dec_s;
      slots_r[idx_r].active <= ~retire_s;
    end else if (spawn_now_s) begin
      slots_r[free_idx_s].active <= 1'b1;
      slots_r[free_idx_s].x      <= SPAWN_X;
      slots_r[free_idx_s].y      <= spawn_y_s;
    end
  end

  // Frames remaining before the next spawn; a blocked spawn keeps it at zero
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      spawn_cnt_r <= '0;
    end else if (Clear) begin
      spawn_cnt_r <= GAP_C;
    end else if (state_r == SPAWN) begin
      if (spawn_cnt_r != '0) begin
        spawn_cnt_r <= spawn_cnt_r - 1'b1;
      end else if (free_found_s) begin
        spawn_cnt_r <= GAP_C + CNT_W'(lfsr_q_s[11:8]);
      end else begin
        spawn_cnt_r <= '0;
      end
    end
  end

  cloud_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .step    (lfsr_step_s),
    .q       (lfsr_q_s)
  );

  for (genvar gi = 0; gi < NUM_CLOUDS; gi++) begin : g_flatten
    assign CloudX[gi*X_W +: X_W] = slots_r[gi].x;
    assign CloudY[gi*Y_W +: Y_W] = slots_r[gi].y;
    assign CloudActive[gi]       = slots_r[gi].active;
  end

  assign Busy      = busy_r;
  assign FrameDone = frame_done_r;

endmodule

// File: tb/tb_cloud_scheduler.sv
// tb_cloud_scheduler: stimulus pushes the expected post-update slot state into
// a queue; a monitor pops and compares it on every FrameDone pulse.
module tb_cloud_scheduler;

  logic        Clk       = 1'b0;
  logic        Reset_n   = 1'b0;
  logic        frame_clk = 1'b0;
  logic        Enable    = 1'b0;
  logic        Clear     = 1'b0;
  logic [43:0] CloudX;
  logic [39:0] CloudY;
  logic [3:0]  CloudActive;
  logic        Busy;
  logic        FrameDone;

  always #5 Clk = ~Clk;

  cloud_scheduler dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .Enable      (Enable),
    .Clear       (Clear),
    .CloudX      (CloudX),
    .CloudY      (CloudY),
    .CloudActive (CloudActive),
    .Busy        (Busy),
    .FrameDone   (FrameDone)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_push   = 0;
  int fd_seen  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // frame-level reference model
  bit          m_act [4];
  int          m_x   [4];
  int          m_y   [4];
  int          m_cnt;
  logic [15:0] m_lfsr;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 1'b0; m_x[i] = 640; m_y[i] = 20;
    end
    m_cnt  = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_scroll(input int i);
    if (m_act[i]) begin
      m_x[i] = m_x[i] - 1;
      if (m_x[i] <= -100) m_act[i] = 1'b0;
    end
  endtask

  task automatic model_frame();
    int f;
    for (int i = 0; i < 4; i++) model_scroll(i);
    f = -1;
    for (int i = 3; i >= 0; i--) if (!m_act[i]) f = i;
    if (m_cnt == 0) begin
      if (f >= 0) begin
        m_act[f] = 1'b1;
        m_x[f]   = 640;
        m_y[f]   = 20 + int'(m_lfsr[6:0]);
        m_cnt    = 120 + int'(m_lfsr[11:8]);
      end
    end else begin
      m_cnt = m_cnt - 1;
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  function automatic logic [3:0] model_act();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_act[i];
    return r;
  endfunction

  function automatic logic [43:0] model_x();
    logic [43:0] r;
    for (int i = 0; i < 4; i++) r[11*i +: 11] = 11'(m_x[i]);
    return r;
  endfunction

  function automatic logic [39:0] model_y();
    logic [39:0] r;
    for (int i = 0; i < 4; i++) r[10*i +: 10] = 10'(m_y[i]);
    return r;
  endfunction

  typedef struct packed {
    logic [3:0]  a;
    logic [43:0] x;
    logic [39:0] y;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;

  task automatic push_frame();
    model_frame();
    exp_q.push_back({model_act(), model_x(), model_y()});
    n_push++;
  endtask

  // monitor: every completed update must match the oldest queued expectation
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && FrameDone === 1'b1) begin
      fd_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_framedone: got FrameDone=1 expected no update");
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_active", 64'(CloudActive), 64'(mon_e.a));
        check("frame_x", 64'(CloudX), 64'(mon_e.x));
        check("frame_y", 64'(CloudY), 64'(mon_e.y));
      end
    end
  end

  // one frame strobe; measures tick->FrameDone latency in Clk edges
  task automatic do_frame(input bit expect_upd, input bit probe_retire);
    int lat;
    lat = 0;
    @(posedge Clk); #1;
    frame_clk = 1'b1;
    if (expect_upd) push_frame();
    for (int k = 1; k <= 14; k++) begin
      @(posedge Clk); #1;
      if (k == 6) frame_clk = 1'b0;
      if (FrameDone === 1'b1 && lat == 0) lat = k;
      if (expect_upd && k == 4) check("busy_in_scan", 64'(Busy), 64'(1));
      if (probe_retire && k == 5) begin
        check("retire_active0", 64'(CloudActive[0]), 64'(0));
        check("retire_x0", 64'(CloudX[10:0]), 64'(11'h79C));
      end
    end
    if (expect_upd) check("frame_latency", 64'(lat), 64'(9));
    else            check("no_update", 64'(lat), 64'(0));
  endtask

  initial begin
    int fd_win;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_active", 64'(CloudActive), 64'(0));
    check("rst_x", 64'(CloudX), 64'({4{11'd640}}));
    check("rst_y", 64'(CloudY), 64'({4{10'd20}}));
    check("rst_busy", 64'(Busy), 64'(0));
    check("rst_framedone", 64'(FrameDone), 64'(0));
    Reset_n = 1'b1;
    Enable  = 1'b1;
    repeat (2) @(posedge Clk);

    // first frame spawns slot 0 at y = 20 + (16'hACE1 & 7'h7F) = 117
    do_frame(1'b1, 1'b0);
    check("first_active", 64'(CloudActive), 64'(4'b0001));
    check("first_x", 64'(CloudX[10:0]), 64'(640));
    check("first_y", 64'(CloudY[9:0]), 64'(117));

    // gap after first spawn is 120 + 4'hC = 132 frames -> second spawn on frame 134
    for (int f = 2; f <= 133; f++) do_frame(1'b1, 1'b0);
    check("gap_before_second", 64'(CloudActive), 64'(4'b0001));
    do_frame(1'b1, 1'b0);
    check("second_spawn", 64'(CloudActive), 64'(4'b0011));

    for (int f = 135; f <= 600; f++) do_frame(1'b1, 1'b0);
    check("all_slots_full", 64'(CloudActive), 64'(4'b1111));

    // slot 0 retires on frame 741 (x = -100) and the held spawn refills it
    for (int f = 601; f <= 740; f++) do_frame(1'b1, 1'b0);
    do_frame(1'b1, 1'b1);
    check("refill_active", 64'(CloudActive), 64'(4'b1111));
    check("refill_x0", 64'(CloudX[10:0]), 64'(640));

    // three edges: one starts, one is pending, one is dropped -> two updates
    push_frame();
    push_frame();
    fd_win = 0;
    @(posedge Clk); #1;
    frame_clk = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge Clk); #1;
      if (k == 2 || k == 4 || k == 6) frame_clk = 1'b0;
      if (k == 3 || k == 5) frame_clk = 1'b1;
      if (FrameDone === 1'b1) fd_win++;
    end
    check("pending_pulses", 64'(fd_win), 64'(2));

    // Clear during scan of slot 2: slots 0,1 already scrolled, no FrameDone
    fd_win = 0;
    @(posedge Clk); #1;
    frame_clk = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      if (FrameDone === 1'b1) fd_win++;
      if (k == 6) begin
        frame_clk = 1'b0;
        Clear     = 1'b1;
      end
      if (k == 7) begin
        Clear = 1'b0;
        model_scroll(0);
        model_scroll(1);
        for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
        m_cnt = 120;
        check("clear_active", 64'(CloudActive), 64'(0));
        check("clear_busy", 64'(Busy), 64'(0));
        check("clear_x", 64'(CloudX), 64'(model_x()));
      end
    end
    check("clear_no_framedone", 64'(fd_win), 64'(0));

    for (int f = 1; f <= 120; f++) do_frame(1'b1, 1'b0);
    check("clear_gap_hold", 64'(CloudActive), 64'(0));
    do_frame(1'b1, 1'b0);
    check("clear_gap_spawn", 64'(CloudActive), 64'(4'b0001));

    // disabled: ticks ignored, outputs frozen, nothing left pending
    Enable = 1'b0;
    for (int f = 0; f < 10; f++) do_frame(1'b0, 1'b0);
    check("disabled_active", 64'(CloudActive), 64'(model_act()));
    check("disabled_x", 64'(CloudX), 64'(model_x()));
    check("disabled_y", 64'(CloudY), 64'(model_y()));
    Enable = 1'b1;
    repeat (15) @(posedge Clk);
    #1;
    check("reenable_idle", 64'(Busy), 64'(0));

    // asynchronous reset in the middle of a scan
    @(posedge Clk); #1;
    frame_clk = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    check("mid_scan_busy", 64'(Busy), 64'(1));
    Reset_n = 1'b0;
    #1;
    check("async_rst_active", 64'(CloudActive), 64'(0));
    check("async_rst_x", 64'(CloudX), 64'({4{11'd640}}));
    check("async_rst_y", 64'(CloudY), 64'({4{10'd20}}));
    check("async_rst_busy", 64'(Busy), 64'(0));
    frame_clk = 1'b0;
    model_reset();
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    do_frame(1'b1, 1'b0);
    check("post_rst_y", 64'(CloudY[9:0]), 64'(117));
    check("post_rst_active", 64'(CloudActive), 64'(4'b0001));

    repeat (5) @(posedge Clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("framedone_count", 64'(fd_seen), 64'(n_push));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
